// File: rtl/seq_match_pkg.sv
// Shared state encodings and reset defaults for the programmable sequence-match controller.
package seq_match_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [15:0] DEF_PATTERN = 16'b101;
    localparam int unsigned DEF_LEN     = 3;
    localparam logic        DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial history register, fill tracker and length-masked pattern compare.
module seq_match_core #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned LW     = $clog2(MAXLEN) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              in_bit,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [LW-1:0]     len,
    output logic              op
);

    logic [MAXLEN-1:0] hist_q, hist_d, cand, mask;
    logic [LW-1:0]     fill_q, fill_d;
    logic [LW:0]       fill_inc;
    logic              full;

    always_comb begin
        cand     = {hist_q[MAXLEN-2:0], in_bit};
        fill_inc = {1'b0, fill_q} + (LW + 1)'(1);
        full     = (fill_inc >= {1'b0, len});
        for (int i = 0; i < MAXLEN; i++) begin
            mask[i] = (i < int'(len));
        end
        op = en && full && (((cand ^ pattern) & mask) == '0);

        hist_d = hist_q;
        fill_d = fill_q;
        // clr wins over a shift so a non-overlapping match restarts from an empty history
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = cand;
            fill_d = full ? len : fill_inc[LW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Run-control FSM, config registers and saturating match counter around the serial matcher.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned CNTW   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [MAXLEN-1:0]         cfg_pattern,
    input  logic [$clog2(MAXLEN):0]   cfg_len,
    input  logic                      cfg_overlap,
    input  logic [CNTW-1:0]           cfg_target,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      in_valid,
    input  logic                      In,
    output logic [1:0]                state,
    output logic                      op,
    output logic [CNTW-1:0]           match_cnt,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned LW = $clog2(MAXLEN) + 1;

    state_e            state_q, state_d;
    logic [MAXLEN-1:0] pattern_q, pattern_d;
    logic [LW-1:0]     len_q, len_d;
    logic              overlap_q, overlap_d;
    logic [CNTW-1:0]   target_q, target_d, cnt_q, cnt_d;
    logic [CNTW:0]     cnt_inc;
    logic              core_en, core_clr;

    // abort masks the match outright, so it never counts or shifts
    assign core_en = (state_q == ST_RUN) && in_valid && !abort;

    seq_match_core #(
        .MAXLEN (MAXLEN),
        .LW     (LW)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (core_clr),
        .en      (core_en),
        .in_bit  (In),
        .pattern (pattern_q),
        .len     (len_q),
        .op      (op)
    );

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        core_clr  = 1'b0;
        cnt_inc   = {1'b0, cnt_q} + (CNTW + 1)'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    overlap_d = cfg_overlap;
                    target_d  = cfg_target;
                    if (cfg_len == '0) begin
                        len_d = LW'(1);
                    end else if (cfg_len > LW'(MAXLEN)) begin
                        len_d = LW'(MAXLEN);
                    end else begin
                        len_d = cfg_len;
                    end
                end
                if (start) begin
                    core_clr = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (op) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_inc[CNTW-1:0];
                    if (!overlap_q) begin
                        core_clr = 1'b1;
                    end
                    if ((target_q != '0) && (cnt_inc == {1'b0, target_q})) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    core_clr = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= MAXLEN'(DEF_PATTERN);
            len_q     <= LW'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            target_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
        end
    end

    assign state     = state_q;
    assign match_cnt = cnt_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed self-checking bench for seq_match_ctrl (MAXLEN=8, CNTW=2).
module tb_seq_match_ctrl;

    localparam int unsigned MAXLEN = 8;
    localparam int unsigned CNTW   = 2;

    logic              clk = 1'b0;
    logic              rst, cfg_we, cfg_overlap, start, abort, in_valid, in_bit;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [3:0]        cfg_len;
    logic [CNTW-1:0]   cfg_target;
    logic [1:0]        state;
    logic              op, busy, done;
    logic [CNTW-1:0]   match_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_match_ctrl #(
        .MAXLEN (MAXLEN),
        .CNTW   (CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .In          (in_bit),
        .state       (state),
        .op          (op),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
    );

    // Apply one data slot, capture combinational op before the edge, clear one-shot controls.
    task automatic cycle(input logic v, input logic b, output logic o);
        in_valid = v;
        in_bit   = b;
        #2;
        o = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        cfg_we   = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                           input logic [1:0] t);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cfg_target  = t;
    endtask

    task automatic test_reset();
        logic o;
        rst = 1'b1;
        cycle(1'b0, 1'b0, o);
        cycle(1'b1, 1'b1, o);
        checks++;
        if (state !== 2'b00) begin
            errors++; $display("FAIL reset_state got=%b exp=00", state);
        end
        checks++;
        if (match_cnt !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_outs cnt=%0d busy=%b done=%b exp=0/0/0",
                                match_cnt, busy, done);
        end
        checks++;
        if (o !== 1'b0) begin
            errors++; $display("FAIL idle_op got=%b exp=0", o);
        end
    endtask

    task automatic test_default_overlap();
        logic [4:0] s  = 5'b10101;
        logic [4:0] ev = 5'b10100;
        logic o;
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        checks++;
        if (state !== 2'b01 || busy !== 1'b1) begin
            errors++; $display("FAIL start_run state=%b busy=%b exp=01/1", state, busy);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, s[i], o);
            checks++;
            if (o !== ev[i]) begin
                errors++; $display("FAIL ovl_op bit%0d got=%b exp=%b", i + 1, o, ev[i]);
            end
        end
        checks++;
        if (match_cnt !== 2'd2 || state !== 2'b01) begin
            errors++; $display("FAIL ovl_cnt cnt=%0d state=%b exp=2/01", match_cnt, state);
        end
        abort = 1'b1;
        cycle(1'b0, 1'b0, o);
    endtask

    task automatic test_no_overlap();
        logic [4:0] s  = 5'b10101;
        logic [4:0] ev = 5'b00100;
        logic o;
        set_cfg(8'b101, 4'd3, 1'b0, 2'd0);
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, s[i], o);
            checks++;
            if (o !== ev[i]) begin
                errors++; $display("FAIL novl_op bit%0d got=%b exp=%b", i + 1, o, ev[i]);
            end
        end
        checks++;
        if (match_cnt !== 2'd1) begin
            errors++; $display("FAIL novl_cnt got=%0d exp=1", match_cnt);
        end
        abort = 1'b1;
        cycle(1'b0, 1'b0, o);
    endtask

    task automatic test_target_done();
        logic [7:0] s  = 8'b11011011;
        logic [7:0] ev = 8'b01001000;
        logic o;
        set_cfg(8'b1101, 4'd4, 1'b1, 2'd2);
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, s[i], o);
            checks++;
            if (o !== ev[i]) begin
                errors++; $display("FAIL tgt_op bit%0d got=%b exp=%b", i + 1, o, ev[i]);
            end
            if (i == 6) begin
                checks++;
                if (state !== 2'b10 || done !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL tgt_done state=%b done=%b busy=%b exp=10/1/0",
                                        state, done, busy);
                end
            end
        end
        checks++;
        if (match_cnt !== 2'd2 || state !== 2'b10) begin
            errors++; $display("FAIL tgt_frozen cnt=%0d state=%b exp=2/10", match_cnt, state);
        end
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        checks++;
        if (match_cnt !== 2'd0 || state !== 2'b01) begin
            errors++; $display("FAIL done_restart cnt=%0d state=%b exp=0/01", match_cnt, state);
        end
        abort = 1'b1;
        cycle(1'b0, 1'b0, o);
    endtask

    task automatic test_cfg_in_run_and_abort();
        logic o;
        set_cfg(8'b101, 4'd3, 1'b1, 2'd0);
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        set_cfg(8'b0000, 4'd4, 1'b1, 2'd0);
        cycle(1'b0, 1'b0, o);
        cycle(1'b1, 1'b1, o);
        cycle(1'b1, 1'b0, o);
        cycle(1'b1, 1'b1, o);
        checks++;
        if (o !== 1'b1) begin
            errors++; $display("FAIL run_cfg_ignored op got=%b exp=1", o);
        end
        cycle(1'b1, 1'b0, o);
        abort = 1'b1;
        cycle(1'b1, 1'b1, o);
        checks++;
        if (o !== 1'b0) begin
            errors++; $display("FAIL abort_op got=%b exp=0", o);
        end
        checks++;
        if (state !== 2'b00 || match_cnt !== 2'd1) begin
            errors++; $display("FAIL abort_state state=%b cnt=%0d exp=00/1", state, match_cnt);
        end
    endtask

    task automatic test_valid_gaps();
        logic o;
        logic [4:0] got;
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        cycle(1'b1, 1'b1, got[0]);
        cycle(1'b0, 1'b0, got[1]);
        cycle(1'b1, 1'b0, got[2]);
        cycle(1'b0, 1'b1, got[3]);
        cycle(1'b1, 1'b1, got[4]);
        checks++;
        if (got !== 5'b10000) begin
            errors++; $display("FAIL gap_ops got=%b exp=10000", got);
        end
        checks++;
        if (match_cnt !== 2'd1) begin
            errors++; $display("FAIL gap_cnt got=%0d exp=1", match_cnt);
        end
        abort = 1'b1;
        cycle(1'b0, 1'b0, o);
    endtask

    task automatic test_len_clamp_saturate();
        logic o;
        logic [1:0] ecnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [7:0] s  = 8'b10100101;
        logic [7:0] ev = 8'b10000000;
        set_cfg(8'b0000_0001, 4'd0, 1'b1, 2'd0);
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, o);
            checks++;
            if (o !== 1'b1 || match_cnt !== ecnt[i]) begin
                errors++; $display("FAIL len0 bit%0d op=%b cnt=%0d exp=1/%0d",
                                    i + 1, o, match_cnt, ecnt[i]);
            end
        end
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        checks++;
        if (match_cnt !== 2'd3 || state !== 2'b01) begin
            errors++; $display("FAIL start_in_run cnt=%0d state=%b exp=3/01", match_cnt, state);
        end
        abort = 1'b1;
        cycle(1'b0, 1'b0, o);
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        checks++;
        if (match_cnt !== 2'd0 || state !== 2'b01) begin
            errors++; $display("FAIL idle_restart cnt=%0d state=%b exp=0/01", match_cnt, state);
        end
        abort = 1'b1;
        cycle(1'b0, 1'b0, o);
        // Oversized length clamps to MAXLEN: only the 8th bit can complete a match.
        set_cfg(8'hA5, 4'd15, 1'b1, 2'd0);
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, s[i], o);
            checks++;
            if (o !== ev[i]) begin
                errors++; $display("FAIL len_max bit%0d got=%b exp=%b", i + 1, o, ev[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic o;
        logic [2:0] got;
        set_cfg(8'b0000_0001, 4'd1, 1'b1, 2'd0);
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        rst = 1'b1;
        cycle(1'b1, 1'b1, o);
        checks++;
        if (state !== 2'b00 || match_cnt !== 2'd0) begin
            errors++; $display("FAIL rst_mid state=%b cnt=%0d exp=00/0", state, match_cnt);
        end
        start = 1'b1;
        cycle(1'b0, 1'b0, o);
        cycle(1'b1, 1'b1, got[0]);
        cycle(1'b1, 1'b0, got[1]);
        cycle(1'b1, 1'b1, got[2]);
        checks++;
        if (got !== 3'b100) begin
            errors++; $display("FAIL rst_cfg_default ops got=%b exp=100", got);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cfg_target  = '0;
        start       = 1'b0;
        abort       = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_default_overlap();
        test_no_overlap();
        test_target_done();
        test_cfg_in_run_and_abort();
        test_valid_gaps();
        test_len_clamp_saturate();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
